// File: rtl/tdm_demux8.sv
// 8-slot TDM demultiplexer: steps a far-end 8:1 selector through its slots and
// samples the serial line once per Tick, then presents the completed frame on Q.
module tdm_demux8 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       Tick,
  input  logic       Din,
  output logic [2:0] Sel,
  output logic [7:0] Q,
  output logic       Valid,
  output logic       Busy,
  output logic       Err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [2:0] slot;
  logic [7:0] shadow;
  logic [7:0] shadow_nxt;
  logic [7:0] q_reg;
  logic       err_reg;
  logic [2:0] bit_idx;

  assign bit_idx = LSB_FIRST ? slot : (3'd7 - slot);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    shadow_nxt          = shadow;
    shadow_nxt[bit_idx] = Din;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      slot    <= 3'd0;
      shadow  <= 8'h00;
      q_reg   <= 8'h00;
      err_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state  <= SHIFT;
            slot   <= 3'd0;
            shadow <= 8'h00;
          end
        end
        SHIFT: begin
          // A Start mid-frame restarts collection and flags the lost frame; its Tick is dropped.
          if (Start) begin
            slot    <= 3'd0;
            shadow  <= 8'h00;
            err_reg <= 1'b1;
          end else if (Tick) begin
            shadow <= shadow_nxt;
            if (slot == 3'd7) begin
              state <= DONE;
              q_reg <= shadow_nxt;
            end else begin
              slot <= slot + 3'd1;
            end
          end
        end
        DONE: begin
          slot   <= 3'd0;
          shadow <= 8'h00;
          state  <= Start ? SHIFT : IDLE;
        end
        default: begin
          state <= IDLE;
          slot  <= 3'd0;
        end
      endcase
    end
  end

  // Q is loaded on the edge that samples slot 7, so the new frame and Valid appear together.
  always_comb begin
    Sel = 3'd0;
    case (state)
      SHIFT:   Sel = slot;
      DONE:    Sel = 3'd7;
      default: Sel = 3'd0;
    endcase
  end

  assign Q     = q_reg;
  assign Valid = (state == DONE);
  assign Busy  = (state != IDLE);
  assign Err   = err_reg;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: one LSB-first and one MSB-first instance share stimulus.
module tb_tdm_demux8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       tick;
  logic       din;
  logic [2:0] sel,   sel_m;
  logic [7:0] q,     q_m;
  logic       valid, valid_m;
  logic       busy,  busy_m;
  logic       err,   err_m;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  tdm_demux8 #(.LSB_FIRST(1'b1)) dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Tick(tick), .Din(din),
    .Sel(sel), .Q(q), .Valid(valid), .Busy(busy), .Err(err)
  );

  tdm_demux8 #(.LSB_FIRST(1'b0)) dut_m (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Tick(tick), .Din(din),
    .Sel(sel_m), .Q(q_m), .Valid(valid_m), .Busy(busy_m), .Err(err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one edge pass, and leave time 1 unit after it.
  task automatic step(input logic s, input logic t, input logic d);
    start = s;
    tick  = t;
    din   = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    tick  = 1'b0;
    din   = 1'b0;
    if (valid) vcount++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    din   = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({sel, q, valid, busy, err} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got sel=%0d q=%h valid=%b busy=%b err=%b exp all 0", sel, q, valid, busy, err);
    end
    start = 1'b1;
    tick  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold got busy=%b sel=%0d exp busy=0 sel=0", busy, sel);
    end
    start = 1'b0;
    tick  = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    int v0;
    pat = 8'h85;
    do_reset();
    v0 = vcount;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || sel !== 3'd0) begin
      failures++;
      $display("FAIL basic_start got busy=%b sel=%0d exp busy=1 sel=0", busy, sel);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (sel !== 3'(k) || valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_sel_step got sel=%0d valid=%b busy=%b exp sel=%0d valid=0 busy=1", sel, valid, busy, k);
      end
      step(1'b0, 1'b1, pat[k]);
    end
    checks++;
    if (valid !== 1'b1 || q !== 8'h85 || sel !== 3'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done got valid=%b q=%h sel=%0d busy=%b exp valid=1 q=85 sel=7 busy=1", valid, q, sel, busy);
    end
    checks++;
    if (q_m !== 8'hA1 || valid_m !== 1'b1) begin
      failures++;
      $display("FAIL msb_first_q got q=%h valid=%b exp q=a1 valid=1", q_m, valid_m);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || q !== 8'h85 || sel !== 3'd0) begin
      failures++;
      $display("FAIL basic_after got valid=%b busy=%b q=%h sel=%0d exp valid=0 busy=0 q=85 sel=0", valid, busy, q, sel);
    end
    checks++;
    if (vcount - v0 !== 1) begin
      failures++;
      $display("FAIL basic_valid_count got %0d exp 1", vcount - v0);
    end
  endtask

  task automatic test_abort();
    int v0;
    do_reset();
    v0 = vcount;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0 || sel !== 3'd4) begin
      failures++;
      $display("FAIL abort_pre got err=%b sel=%0d exp err=0 sel=4", err, sel);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b1 || sel !== 3'd0 || busy !== 1'b1 || vcount != v0) begin
      failures++;
      $display("FAIL abort_restart got err=%b sel=%0d busy=%b valids=%0d exp err=1 sel=0 busy=1 valids=0", err, sel, busy, vcount - v0);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || q !== 8'h00 || err !== 1'b1) begin
      failures++;
      $display("FAIL abort_done got valid=%b q=%h err=%b exp valid=1 q=00 err=1", valid, q, err);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || vcount - v0 !== 1) begin
      failures++;
      $display("FAIL abort_sticky got err=%b valids=%0d exp err=1 valids=1", err, vcount - v0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'h3C;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1);
    checks++;
    if (valid !== 1'b1 || q !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_frame_a got valid=%b q=%h exp valid=1 q=ff", valid, q);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || sel !== 3'd0 || err !== 1'b0 || q !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_restart got valid=%b busy=%b sel=%0d err=%b q=%h exp valid=0 busy=1 sel=0 err=0 q=ff", valid, busy, sel, err, q);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, pat[k]);
    checks++;
    if (valid !== 1'b1 || q !== 8'h3C || q_m !== 8'h3C || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_frame_b got valid=%b q=%h q_m=%h err=%b exp valid=1 q=3c q_m=3c err=0", valid, q, q_m, err);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat;
    int v0;
    pat = 8'h85;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
    checks++;
    if (sel !== 3'd5) begin
      failures++;
      $display("FAIL async_mid got sel=%0d exp 5", sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, q, valid, busy, err} !== 14'd0 || {sel_m, q_m, valid_m, busy_m, err_m} !== 14'd0) begin
      failures++;
      $display("FAIL async_now got sel=%0d q=%h valid=%b busy=%b err=%b exp all 0", sel, q, valid, busy, err);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    v0 = vcount;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || q !== 8'h00) begin
      failures++;
      $display("FAIL async_first_start got busy=%b q=%h exp busy=1 q=00", busy, q);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, pat[k]);
    checks++;
    if (valid !== 1'b1 || q !== 8'h85 || vcount - v0 !== 1) begin
      failures++;
      $display("FAIL async_after got valid=%b q=%h valids=%0d exp valid=1 q=85 valids=1", valid, q, vcount - v0);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] pat;
    pat = 8'h5A;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (busy !== 1'b0 || sel !== 3'd0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL ignored_idle_tick got busy=%b sel=%0d valid=%b exp 0 0 0", busy, sel, valid);
      end
    end
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1 || sel !== 3'd0) begin
      failures++;
      $display("FAIL ignored_start_tick got busy=%b sel=%0d exp busy=1 sel=0", busy, sel);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, pat[k]);
    checks++;
    if (valid !== 1'b1 || q !== 8'h5A || q_m !== 8'h5A) begin
      failures++;
      $display("FAIL ignored_frame got valid=%b q=%h q_m=%h exp valid=1 q=5a q_m=5a", valid, q, q_m);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || q !== 8'h5A || valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_done_tick got busy=%b q=%h valid=%b exp busy=0 q=5a valid=0", busy, q, valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have one parameter: LSB_FIRST, default 1, slot k maps to Q[k] when 1 and to Q[7-k] when 0.
REQ-002 Clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  frame-start strobe, sampled on a rising edge of Clock.
REQ-005 Tick  input  1  slot-sample strobe, one Clock cycle wide.
REQ-006 Din  input  1  serial line from the far-end 8:1 selector.
REQ-007 Sel  output  3  current slot index; drives the far-end selector lines.
REQ-008 Q  output  8  last completed frame.
REQ-009 Valid  output  1  one-cycle pulse; Q was updated this cycle.
REQ-010 Busy  output  1  high while a frame is being collected.
REQ-011 Err  output  1  sticky frame-abort flag.

Function
REQ-012 The FSM SHALL have 3 states: IDLE, SHIFT and DONE.
REQ-013 IDLE: Busy=0, Sel=0; on Start=1 go to SHIFT with slot=0 and shadow register=8'h00; Tick is ignored.
REQ-014 SHIFT: Busy=1, Sel=slot; on Tick=1 write Din into shadow bit map(slot); if slot<7 increment slot, else go to DONE.
REQ-015 DONE: lasts exactly 1 cycle; Q<=shadow, Valid=1, Busy=1, Sel=7; then go to IDLE.
REQ-016 Latency: Valid and the new Q SHALL be visible in the cycle after the edge that samples slot 7, i.e. 1 cycle after the 8th accepted Tick.
REQ-017 Q SHALL hold its value in all cycles except when Valid=1.
REQ-018 Valid SHALL be high only in DONE and never on 2 consecutive cycles unless DONE is entered again.
REQ-019 Slot SHALL be 3 bits; it never wraps inside SHIFT; the exit from SHIFT happens at slot 7.
REQ-020 In SHIFT, Start=1 SHALL abort the frame: slot=0, shadow=8'h00, stay in SHIFT, set Err=1; a simultaneous Tick is discarded.
REQ-021 In DONE, Start=1 SHALL still complete the frame (Q updated, Valid=1), then go directly to SHIFT with slot=0, and SHALL NOT set Err.
REQ-022 Tick in DONE or IDLE SHALL be discarded.
REQ-023 Err SHALL clear only on reset; it has no other clear path.
REQ-024 Din SHALL be sampled only on cycles with Tick=1 in SHIFT; Din at all other times is don't-care.

Reset
REQ-025 Resetn=0 SHALL force at once, without Clock: state=IDLE, slot=0, shadow=8'h00, Q=8'h00, Sel=0, Valid=0, Busy=0, Err=0.
REQ-026 Reset in mid-frame SHALL discard the partial frame; Q SHALL NOT update from it.
REQ-027 After Resetn rises, the first Start SHALL be honoured on the first rising edge.

Verification
REQ-028 Basic frame, LSB_FIRST=1: Start, then 8 Ticks 3 cycles apart with Din=1,0,1,0,0,0,0,1 -> Sel steps 0..7; Q=8'h85 with Valid high for 1 cycle, 1 cycle after the 8th Tick; Busy falls on the next cycle.
REQ-029 Bit order, LSB_FIRST=0, same stimulus -> Q=8'hA1.
REQ-030 Abort: Start; 4 Ticks with Din=1; Start again; 8 Ticks with Din=0 -> Err=1; Q=8'h00 with 1 Valid pulse; no Valid pulse before the restart.
REQ-031 Back-to-back frames: Start asserted in the DONE cycle of frame A (8'hFF) -> Valid for A; next cycle Busy=1 and Sel=0; Err stays 0; frame B (8'h3C) completes correctly.
REQ-032 Async reset: frame at slot 5; drop Resetn between edges -> all outputs are 0 at once; Q stays 8'h00; a frame after reset completes normally.
REQ-033 Ignored strobes: Ticks in IDLE, plus Start and Tick in the same cycle in IDLE -> slot 0 is sampled only on the next Tick; Sel=0 until that Tick.
